// File: rtl/row_fill_arbiter.sv
// Round-robin arbiter: grants one requester a whole DEPTH-word line, streams its words to a shared collector, then holds the completed line.
// Latency: grant is registered one cycle after a request is seen in IDLE. Each accepted word is written in the same cycle. line_valid rises the cycle after the last word.
// Backpressure: only the granted requester sees s_ready, and only while filling. A completed line is held until line_ready, and no new grant is issued meanwhile.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   req[NREQ]                per-requester line-fill request
//   grant[NREQ]              registered one-hot grant (zero when idle)
//   s_valid/s_ready[NREQ]    per-requester word handshake; s_data packs requester i at [i*DW +: DW]
//   wr_en/wr_idx/wr_data     write port into the shared line collector
//   line_valid/line_src      completed line and its owner; line_ready consumes it
//   busy                     high while a line is being filled or held
module row_fill_arbiter #(
    parameter int DW    = 32,
    parameter int DEPTH = 56,
    parameter int NREQ  = 4,
    localparam int SW   = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    output logic [NREQ-1:0]    grant,
    input  logic [NREQ-1:0]    s_valid,
    input  logic [NREQ*DW-1:0] s_data,
    output logic [NREQ-1:0]    s_ready,
    output logic               wr_en,
    output logic [5:0]         wr_idx,
    output logic [DW-1:0]      wr_data,
    output logic               line_valid,
    output logic [SW-1:0]      line_src,
    input  logic               line_ready,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [SW-1:0]   owner_q, owner_d;     // index form of grant_q
    logic [5:0]      cnt_q, cnt_d;         // next word slot to be written
    logic [SW-1:0]   rr_ptr_q, rr_ptr_d;   // first requester to consider in IDLE
    logic            line_valid_q, line_valid_d;

    logic            win_found;
    logic [SW-1:0]   win_idx;
    logic [SW-1:0]   win_next;

    // Round-robin search: scan requesters starting at rr_ptr_q, wrapping
    // modulo NREQ. The sum is one bit wider so that it cannot overflow
    // before the wrap is applied.
    always_comb begin
        logic [SW:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (SW+1)'(k);
            if (cand >= (SW+1)'(NREQ)) begin
                cand = cand - (SW+1)'(NREQ);
            end
            if (!win_found && req[cand[SW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[SW-1:0];
            end
        end
    end

    assign win_next = (win_idx == SW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        rr_ptr_d     = rr_ptr_q;
        line_valid_d = line_valid_q;
        s_ready      = '0;
        wr_en        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d  = ST_FILL;
                    grant_d  = NREQ'(1) << win_idx;
                    owner_d  = win_idx;
                    cnt_d    = '0;
                    rr_ptr_d = win_next;
                end
            end
            ST_FILL: begin
                // The grant is locked here: req is not consulted again until
                // the full line has been transferred.
                s_ready = grant_q;
                if (|(s_valid & grant_q)) begin
                    wr_en = 1'b1;
                    if (cnt_q == 6'(DEPTH - 1)) begin
                        cnt_d        = '0;
                        state_d      = ST_HOLD;
                        line_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (line_ready) begin
                    state_d      = ST_IDLE;
                    grant_d      = '0;
                    line_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            cnt_q        <= '0;
            rr_ptr_q     <= '0;
            line_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            line_valid_q <= line_valid_d;
        end
    end

    assign grant      = grant_q;
    assign wr_idx     = cnt_q;
    assign wr_data    = s_data[int'(owner_q)*DW +: DW];
    assign line_valid = line_valid_q;
    assign line_src   = owner_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_row_fill_arbiter.sv
module tb_row_fill_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 56;
    localparam int NREQ  = 4;
    localparam int SW    = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    s_valid;
    logic [NREQ*DW-1:0] s_data;
    logic [NREQ-1:0]    s_ready;
    logic               wr_en;
    logic [5:0]         wr_idx;
    logic [DW-1:0]      wr_data;
    logic               line_valid;
    logic [SW-1:0]      line_src;
    logic               line_ready;
    logic               busy;

    always #5 clk = ~clk;

    row_fill_arbiter #(.DW(DW), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .grant      (grant),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .line_valid (line_valid),
        .line_src   (line_src),
        .line_ready (line_ready),
        .busy       (busy)
    );

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } wr_exp_t;

    typedef struct {
        int who;
        int at;
    } ev_t;

    wr_exp_t wr_q[$];
    ev_t     line_q[$];
    ev_t     grant_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: which requester owns the line (-1 if none), what
    // phase the transfer is in, how many words it has delivered so far,
    // and where the next round-robin search begins.
    int m_phase = 0;   // 0 waiting for requests, 1 transferring, 2 line held
    int m_owner = -1;
    int m_words = 0;
    int m_rr    = 0;

    logic rst_at_edge = 1'b0;
    always @(posedge clk) rst_at_edge <= rst;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs and advance the model across the coming edge.
    task automatic step(input logic r, input logic [NREQ-1:0] rq,
                        input logic [NREQ-1:0] sv, input logic lr);
        rst        = r;
        req        = rq;
        s_valid    = sv;
        line_ready = lr;
        for (int i = 0; i < NREQ; i++) s_data[i*DW +: DW] = $urandom;
        cyc++;

        if (m_phase == 1 && sv[m_owner]) begin
            wr_q.push_back('{m_words, s_data[m_owner*DW +: DW]});
        end

        if (r) begin
            m_phase = 0;
            m_owner = -1;
            m_words = 0;
            m_rr    = 0;
        end else if (m_phase == 0) begin
            int w;
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_rr + k) % NREQ;
                if (w < 0 && rq[c]) w = c;
            end
            if (w >= 0) begin
                grant_q.push_back('{w, cyc + 1});
                m_owner = w;
                m_words = 0;
                m_rr    = (w + 1) % NREQ;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (sv[m_owner]) begin
                m_words++;
                if (m_words == DEPTH) begin
                    line_q.push_back('{m_owner, cyc + 1});
                    m_words = 0;
                    m_phase = 2;
                end
            end
        end else begin
            if (lr) begin
                m_phase = 0;
                m_owner = -1;
            end
        end
    endtask

    // Monitor: samples outputs mid-cycle, after the driver has pushed.
    initial begin
        bit              started;
        logic            prev_lv;
        logic [NREQ-1:0] prev_grant;
        int              held_src;
        started    = 1'b0;
        prev_lv    = 1'b0;
        prev_grant = '0;
        held_src   = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_at_edge) begin
                started = 1'b1;
                check("rst_grant", grant, 0);
                check("rst_s_ready", s_ready, 0);
                check("rst_wr_en", wr_en, 0);
                check("rst_wr_idx", wr_idx, 0);
                check("rst_line_valid", line_valid, 0);
                check("rst_line_src", line_src, 0);
                check("rst_busy", busy, 0);
                prev_lv    = 1'b0;
                prev_grant = '0;
            end else if (started) begin
                check("grant_onehot0", $onehot0(grant), 1);
                check("s_ready_subset", (s_ready == 0) || (s_ready == grant), 1);
                check("busy_vs_grant", busy, grant != 0);

                if (wr_en) begin
                    if (wr_q.size() == 0) begin
                        check("wr_unexpected", 1, 0);
                    end else begin
                        wr_exp_t e;
                        e = wr_q.pop_front();
                        check("wr_idx", wr_idx, e.idx);
                        check("wr_data", wr_data, e.data);
                    end
                end else if (wr_q.size() != 0) begin
                    void'(wr_q.pop_front());
                    check("wr_missing", 0, 1);
                end

                if (grant != 0 && grant != prev_grant) begin
                    if (grant_q.size() == 0) begin
                        check("grant_unexpected", grant, 0);
                    end else begin
                        ev_t g;
                        g = grant_q.pop_front();
                        check("grant", grant, 64'(1) << g.who);
                        check("grant_cycle", cyc, g.at);
                    end
                end

                if (line_valid && !prev_lv) begin
                    if (line_q.size() == 0) begin
                        check("line_unexpected", 1, 0);
                    end else begin
                        ev_t l;
                        l = line_q.pop_front();
                        held_src = l.who;
                        check("line_src", line_src, l.who);
                        check("line_cycle", cyc, l.at);
                    end
                end else if (line_valid) begin
                    check("line_src_held", line_src, held_src);
                    check("hold_no_write", wr_en, 0);
                end

                prev_lv    = line_valid;
                prev_grant = grant;
            end
        end
    end

    initial begin
        logic [NREQ-1:0] rq;
        logic [NREQ-1:0] sv;
        logic            lr;
        logic            r;
        bit              rst_done;

        rq = '0;
        rst_done = 1'b0;
        step(1'b1, '0, '0, 1'b0);
        repeat (2) begin
            @(negedge clk);
            step(1'b1, '0, '0, 1'b0);
        end

        // Single requester, continuous data.
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            step(1'b0, 4'b0001, 4'b0001, 1'b1);
        end
        // All requesting, full rotation of the round-robin pointer.
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            step(1'b0, 4'b1111, 4'b1111, 1'b1);
        end
        // Requester 2 with valid toggling every cycle.
        for (int c = 0; c < 250; c++) begin
            @(negedge clk);
            step(1'b0, 4'b0100, (c % 2 == 0) ? 4'b0100 : 4'b0000, 1'b1);
        end
        // Downstream backpressure with all requesting.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            step(1'b0, 4'b1111, 4'b1111, ($urandom_range(0, 24) == 0));
        end
        // Reset part-way through a line, then requester 2 alone.
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            r = (!rst_done && m_phase == 1 && m_words == 31);
            if (r) rst_done = 1'b1;
            step(r, 4'b0100, 4'b0100, 1'b1);
        end
        // Random: requests that come and go (including mid-fill drops),
        // stalls, backpressure and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 7) == 0) rq[i] = ~rq[i];
            end
            for (int i = 0; i < NREQ; i++) sv[i] = ($urandom_range(0, 9) < 7);
            lr = $urandom_range(0, 1) == 1;
            r  = ($urandom_range(0, 399) == 0);
            step(r, rq, sv, lr);
        end
        // Drain.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            step(1'b0, '0, '0, 1'b1);
        end
        @(negedge clk);
        #3;
        check("wr_queue_drained", wr_q.size(), 0);
        check("line_queue_drained", line_q.size(), 0);
        check("grant_queue_drained", grant_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
